// File: rtl/jtcontra_snd_mailbox_pkg.sv
// Shared sound-side definitions for the Contra sound mailbox.
//   IRQ_LEVEL : snd_irq_n low while the command FIFO holds any word.
//   IRQ_EDGE  : snd_irq_n low from an accepted push until snd_irq_clr.
package jtcontra_snd_mailbox_pkg;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  // True when the given mode asks for a latched (push-set) interrupt.
  function automatic bit irq_is_edge(input int mode);
    return mode == IRQ_EDGE;
  endfunction

endpackage

// File: rtl/jtcontra_mbox_fifo.sv
// Command FIFO between main CPU and sound CPU, first-word-fall-through.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   push, din        push strobe and word (dropped when full unless popping)
//   pop              pop strobe (ignored when empty)
//   dout             head word, combinational from the read pointer
//   cnt              entry count, 0 .. 2**AW
//   full, empty      decoded from cnt
//   push_ok          push accepted this cycle
module jtcontra_mbox_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty,
  output logic          push_ok
);

  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok;

  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign cnt    = cnt_q;
  assign dout   = mem[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_ok = push && (!full || pop_ok);

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage has no reset; the pointers/count make stale words
  // unreachable, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jtcontra_snd_mailbox.sv
// Main-CPU to sound-CPU mailbox: command FIFO, sound interrupt, overflow
// flag and a single-word reply latch back to the main CPU.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   main_we, main_din                 command push
//   main_full, main_ovf, main_ovf_clr FIFO full, sticky overflow and its clear
//   main_reply, main_reply_vld/_ack   reply word, pending flag, acknowledge
//   snd_rd, snd_dout, snd_empty       pop strobe, head word, empty flag
//   snd_cnt                           FIFO entry count
//   snd_irq_n, snd_irq_clr            active-low IRQ, clear (edge mode only)
//   snd_reply_we, snd_reply_din       reply latch write
module jtcontra_snd_mailbox
  import jtcontra_snd_mailbox_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int IRQ_MODE = IRQ_LEVEL
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          main_we,
  input  logic [DW-1:0] main_din,
  output logic          main_full,
  output logic          main_ovf,
  input  logic          main_ovf_clr,
  output logic [DW-1:0] main_reply,
  output logic          main_reply_vld,
  input  logic          main_reply_ack,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          snd_empty,
  output logic [AW:0]   snd_cnt,
  output logic          snd_irq_n,
  input  logic          snd_irq_clr,
  input  logic          snd_reply_we,
  input  logic [DW-1:0] snd_reply_din
);

  logic push_ok;
  logic ovf_q,   ovf_d;
  logic irq_q,   irq_d;
  logic [DW-1:0] reply_q, reply_d;
  logic vld_q,   vld_d;

  jtcontra_mbox_fifo #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (main_we),
    .din     (main_din),
    .pop     (snd_rd),
    .dout    (snd_dout),
    .cnt     (snd_cnt),
    .full    (main_full),
    .empty   (snd_empty),
    .push_ok (push_ok)
  );

  always_comb begin
    // Overflow: a dropped push sets the flag; set beats clear.
    ovf_d = ovf_q;
    if (main_ovf_clr)          ovf_d = 1'b0;
    if (main_we && !push_ok)   ovf_d = 1'b1;

    // Level mode registers (cnt != 0), so the IRQ trails the count by a clk.
    // Edge mode latches on each accepted push; set beats clear.
    irq_d = irq_q;
    if (irq_is_edge(IRQ_MODE)) begin
      if (snd_irq_clr) irq_d = 1'b0;
      if (push_ok)     irq_d = 1'b1;
    end else begin
      irq_d = (snd_cnt != '0);
    end

    // Reply latch: a write beats a simultaneous acknowledge.
    reply_d = reply_q;
    vld_d   = vld_q;
    if (main_reply_ack) vld_d = 1'b0;
    if (snd_reply_we) begin
      reply_d = snd_reply_din;
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
      reply_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      reply_q <= reply_d;
      vld_q   <= vld_d;
    end
  end

  assign main_ovf       = ovf_q;
  assign snd_irq_n      = ~irq_q;
  assign main_reply     = reply_q;
  assign main_reply_vld = vld_q;

endmodule

// File: tb/tb_jtcontra_snd_mailbox.sv
module tb_jtcontra_snd_mailbox;

  logic       clk = 1'b0;
  logic       rstn;
  logic       main_we, main_ovf_clr, main_reply_ack;
  logic [7:0] main_din;
  logic       snd_rd, snd_irq_clr, snd_reply_we;
  logic [7:0] snd_reply_din;

  // Level-mode instance outputs
  logic       full_l, ovf_l, vld_l, empty_l, irq_n_l;
  logic [7:0] reply_l, dout_l;
  logic [2:0] cnt_l;
  // Edge-mode instance outputs (same stimulus)
  logic       full_e, ovf_e, vld_e, empty_e, irq_n_e;
  logic [7:0] reply_e, dout_e;
  logic [2:0] cnt_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtcontra_snd_mailbox #(.DW(8), .AW(2), .IRQ_MODE(0)) dut_l (
    .clk(clk), .rstn(rstn),
    .main_we(main_we), .main_din(main_din), .main_full(full_l),
    .main_ovf(ovf_l), .main_ovf_clr(main_ovf_clr),
    .main_reply(reply_l), .main_reply_vld(vld_l), .main_reply_ack(main_reply_ack),
    .snd_rd(snd_rd), .snd_dout(dout_l), .snd_empty(empty_l), .snd_cnt(cnt_l),
    .snd_irq_n(irq_n_l), .snd_irq_clr(snd_irq_clr),
    .snd_reply_we(snd_reply_we), .snd_reply_din(snd_reply_din)
  );

  jtcontra_snd_mailbox #(.DW(8), .AW(2), .IRQ_MODE(1)) dut_e (
    .clk(clk), .rstn(rstn),
    .main_we(main_we), .main_din(main_din), .main_full(full_e),
    .main_ovf(ovf_e), .main_ovf_clr(main_ovf_clr),
    .main_reply(reply_e), .main_reply_vld(vld_e), .main_reply_ack(main_reply_ack),
    .snd_rd(snd_rd), .snd_dout(dout_e), .snd_empty(empty_e), .snd_cnt(cnt_e),
    .snd_irq_n(irq_n_e), .snd_irq_clr(snd_irq_clr),
    .snd_reply_we(snd_reply_we), .snd_reply_din(snd_reply_din)
  );

  // One clock with the currently driven strobes, then release them; ends
  // 1 time unit after the rising edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
    main_we = 0; snd_rd = 0; main_ovf_clr = 0; main_reply_ack = 0;
    snd_irq_clr = 0; snd_reply_we = 0;
  endtask

  task automatic push(input logic [7:0] d);
    main_we = 1; main_din = d;
    step();
  endtask

  task automatic pop();
    snd_rd = 1;
    step();
  endtask

  task automatic test_reset();
    rstn = 0; main_we = 0; main_din = 0; main_ovf_clr = 0; main_reply_ack = 0;
    snd_rd = 0; snd_irq_clr = 0; snd_reply_we = 0; snd_reply_din = 0;
    #2;
    total++; if (cnt_l !== 3'd0)  begin bad++; $display("FAIL rst_cnt got %0d want 0", cnt_l); end
    total++; if (empty_l !== 1'b1) begin bad++; $display("FAIL rst_empty got %b want 1", empty_l); end
    total++; if (full_l !== 1'b0)  begin bad++; $display("FAIL rst_full got %b want 0", full_l); end
    total++; if (ovf_l !== 1'b0)   begin bad++; $display("FAIL rst_ovf got %b want 0", ovf_l); end
    total++; if (vld_l !== 1'b0)   begin bad++; $display("FAIL rst_vld got %b want 0", vld_l); end
    total++; if (reply_l !== 8'h00) begin bad++; $display("FAIL rst_reply got %h want 00", reply_l); end
    total++; if (irq_n_l !== 1'b1 || irq_n_e !== 1'b1)
      begin bad++; $display("FAIL rst_irq got %b/%b want 1/1", irq_n_l, irq_n_e); end
    repeat (2) @(posedge clk);
    #3 rstn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    push(8'h11); push(8'h22); push(8'h33);
    total++; if (cnt_l !== 3'd3)   begin bad++; $display("FAIL basic_cnt got %0d want 3", cnt_l); end
    total++; if (dout_l !== 8'h11) begin bad++; $display("FAIL basic_head got %h want 11", dout_l); end
    pop();
    total++; if (dout_l !== 8'h22) begin bad++; $display("FAIL basic_pop1 got %h want 22", dout_l); end
    pop();
    total++; if (dout_l !== 8'h33) begin bad++; $display("FAIL basic_pop2 got %h want 33", dout_l); end
    pop();
    total++; if (empty_l !== 1'b1 || cnt_l !== 3'd0)
      begin bad++; $display("FAIL basic_empty got empty=%b cnt=%0d want 1/0", empty_l, cnt_l); end
    pop(); // pop on empty is ignored
    total++; if (cnt_l !== 3'd0 || empty_l !== 1'b1)
      begin bad++; $display("FAIL underflow got cnt=%0d empty=%b want 0/1", cnt_l, empty_l); end
  endtask

  task automatic test_irq_level();
    step();
    push(8'h44);
    total++; if (irq_n_l !== 1'b1) begin bad++; $display("FAIL lvl_lag_set got %b want 1", irq_n_l); end
    step();
    total++; if (irq_n_l !== 1'b0) begin bad++; $display("FAIL lvl_set got %b want 0", irq_n_l); end
    pop();
    total++; if (irq_n_l !== 1'b0) begin bad++; $display("FAIL lvl_lag_clr got %b want 0", irq_n_l); end
    step();
    total++; if (irq_n_l !== 1'b1) begin bad++; $display("FAIL lvl_clr got %b want 1", irq_n_l); end
  endtask

  task automatic test_overflow();
    push(8'hA0); push(8'hA1); push(8'hA2);
    total++; if (full_l !== 1'b0) begin bad++; $display("FAIL ovf_full3 got %b want 0", full_l); end
    push(8'hA3);
    total++; if (full_l !== 1'b1 || ovf_l !== 1'b0)
      begin bad++; $display("FAIL ovf_full4 got full=%b ovf=%b want 1/0", full_l, ovf_l); end
    push(8'hA4);
    total++; if (ovf_l !== 1'b1 || cnt_l !== 3'd4)
      begin bad++; $display("FAIL ovf_set got ovf=%b cnt=%0d want 1/4", ovf_l, cnt_l); end
    main_ovf_clr = 1; push(8'hA5); // set beats clear
    total++; if (ovf_l !== 1'b1) begin bad++; $display("FAIL ovf_setwins got %b want 1", ovf_l); end
    main_ovf_clr = 1; step();
    total++; if (ovf_l !== 1'b0) begin bad++; $display("FAIL ovf_clr got %b want 0", ovf_l); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dout_l !== 8'hA0 + 8'(i))
        begin bad++; $display("FAIL ovf_pop%0d got %h want %h", i, dout_l, 8'hA0 + 8'(i)); end
      pop();
    end
    total++; if (empty_l !== 1'b1) begin bad++; $display("FAIL ovf_drain got %b want 1", empty_l); end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp [4];
    exp[0] = 8'hB2; exp[1] = 8'hB3; exp[2] = 8'hB4; exp[3] = 8'hB5;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    snd_rd = 1; push(8'hB5);
    total++; if (cnt_l !== 3'd4 || ovf_l !== 1'b0)
      begin bad++; $display("FAIL fullsim got cnt=%0d ovf=%b want 4/0", cnt_l, ovf_l); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dout_l !== exp[i])
        begin bad++; $display("FAIL fullsim_pop%0d got %h want %h", i, dout_l, exp[i]); end
      pop();
    end
  endtask

  task automatic test_empty_simul();
    snd_rd = 1; push(8'hE7);
    total++; if (cnt_l !== 3'd1 || dout_l !== 8'hE7)
      begin bad++; $display("FAIL emptysim got cnt=%0d dout=%h want 1/e7", cnt_l, dout_l); end
    pop();
  endtask

  task automatic test_irq_edge();
    snd_irq_clr = 1; step();
    total++; if (irq_n_e !== 1'b1) begin bad++; $display("FAIL edge_idle got %b want 1", irq_n_e); end
    push(8'hC1);
    total++; if (irq_n_e !== 1'b0) begin bad++; $display("FAIL edge_set got %b want 0", irq_n_e); end
    snd_irq_clr = 1; step();
    total++; if (irq_n_e !== 1'b1 || cnt_e !== 3'd1)
      begin bad++; $display("FAIL edge_clr got irq_n=%b cnt=%0d want 1/1", irq_n_e, cnt_e); end
    snd_irq_clr = 1; push(8'hC2);
    total++; if (irq_n_e !== 1'b0) begin bad++; $display("FAIL edge_setwins got %b want 0", irq_n_e); end
    snd_irq_clr = 1; step();
    pop(); pop();
  endtask

  task automatic test_reply();
    snd_reply_we = 1; snd_reply_din = 8'h5A; main_reply_ack = 1; step();
    total++; if (reply_l !== 8'h5A || vld_l !== 1'b1)
      begin bad++; $display("FAIL reply_wwins got %h/%b want 5a/1", reply_l, vld_l); end
    snd_reply_we = 1; snd_reply_din = 8'h6B; step();
    total++; if (reply_l !== 8'h6B || vld_l !== 1'b1)
      begin bad++; $display("FAIL reply_over got %h/%b want 6b/1", reply_l, vld_l); end
    main_reply_ack = 1; step();
    total++; if (vld_l !== 1'b0 || reply_l !== 8'h6B)
      begin bad++; $display("FAIL reply_ack got %h/%b want 6b/0", reply_l, vld_l); end
  endtask

  task automatic test_reset_async();
    push(8'hD1); push(8'hD2); push(8'hD3);
    snd_reply_we = 1; snd_reply_din = 8'h77; step();
    total++; if (irq_n_e !== 1'b0 || irq_n_l !== 1'b0 || cnt_l !== 3'd3)
      begin bad++; $display("FAIL arst_pre got %b/%b cnt=%0d want 0/0/3", irq_n_l, irq_n_e, cnt_l); end
    #2 rstn = 0;
    #1;
    total++; if (cnt_l !== 3'd0 || cnt_e !== 3'd0 || empty_l !== 1'b1)
      begin bad++; $display("FAIL arst_cnt got %0d/%0d empty=%b want 0/0/1", cnt_l, cnt_e, empty_l); end
    total++; if (irq_n_l !== 1'b1 || irq_n_e !== 1'b1)
      begin bad++; $display("FAIL arst_irq got %b/%b want 1/1", irq_n_l, irq_n_e); end
    total++; if (vld_l !== 1'b0 || reply_l !== 8'h00)
      begin bad++; $display("FAIL arst_reply got %h/%b want 00/0", reply_l, vld_l); end
    @(negedge clk); #2 rstn = 1;
    @(posedge clk); #1;
    push(8'hF1);
    total++; if (cnt_l !== 3'd1 || dout_l !== 8'hF1)
      begin bad++; $display("FAIL arst_resume got cnt=%0d dout=%h want 1/f1", cnt_l, dout_l); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_irq_level();
    test_overflow();
    test_full_simul();
    test_empty_simul();
    test_irq_edge();
    test_reply();
    test_reset_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
